// File: rtl/nand_bist_pkg.sv
// Shared types and helpers for the NAND datapath BIST sequencer.
// Optional LFSR pattern source is enabled by defining NAND_BIST_LFSR_EN.
package nand_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Feedback masks for maximal-length Fibonacci LFSRs, by register length.
  function automatic logic [31:0] lfsr_taps(input int n);
    case (n)
      2:       lfsr_taps = 32'h0000_0003;
      4:       lfsr_taps = 32'h0000_000C;
      6:       lfsr_taps = 32'h0000_0030;
      8:       lfsr_taps = 32'h0000_00B8;
      10:      lfsr_taps = 32'h0000_0240;
      12:      lfsr_taps = 32'h0000_0829;
      14:      lfsr_taps = 32'h0000_2015;
      16:      lfsr_taps = 32'h0000_D008;
      default: lfsr_taps = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [15:0] nand_gold(
    input logic [15:0] a,
    input logic [15:0] b
  );
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_bist_if.sv
// Operand/result bus between the BIST sequencer and the NAND core.
// Sequencer drives operands, core returns dut_y LAT cycles later.
interface nand_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_valid;
  logic [WIDTH-1:0] dut_y;

  modport master (
    output dut_a,
    output dut_b,
    output dut_valid,
    input  dut_y
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_valid,
    output dut_y
  );
endinterface

// File: rtl/nand_bist_patgen.sv
// Pattern source: binary counter, or a seeded LFSR when
// NAND_BIST_LFSR_EN is defined. Holds on its last pattern.
module nand_bist_patgen
  import nand_bist_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [N-1:0] pat,
  output logic         last
);

`ifdef NAND_BIST_LFSR_EN
  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));
  localparam logic [N-1:0] SEED = N'(1);

  logic [N-1:0] nxt;

  // Shift left, feedback from the tap parity.
  always_comb begin
    nxt = {pat[N-2:0], ^(pat & TAPS)};
  end

  assign last = (nxt == SEED);

  // Reseed on load; stop before the sequence returns to the seed.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      pat <= SEED;
    end else if (step && !last) begin
      pat <= nxt;
    end
  end
`else
  assign last = &pat;

  // Count up from zero; never wraps into a second pass.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      pat <= '0;
    end else if (step && !last) begin
      pat <= pat + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/nand_bist_ctrl.sv
// BIST sequencer: streams patterns, checks delayed results, reports.
// Define NAND_BIST_LFSR_EN for the LFSR pattern source.
module nand_bist_ctrl
  import nand_bist_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAT   = 2,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  nand_bist_if.master      dp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int N = 2 * WIDTH;

  state_e           state_q;
  state_e           state_d;
  logic             load;
  logic [3:0]       dcnt;
  logic [N-1:0]     pat;
  logic             last;
  logic             run;
  logic             mis;
  logic [LAT-1:0]   pv;
  logic [WIDTH-1:0] pa [LAT];
  logic [WIDTH-1:0] pb [LAT];

  nand_bist_patgen #(.N(N)) u_patgen (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (run),
    .pat  (pat),
    .last (last)
  );

  assign run          = (state_q == RUN);
  assign dp.dut_valid = run;
  assign dp.dut_a     = run ? pat[N-1:WIDTH] : '0;
  assign dp.dut_b     = run ? pat[WIDTH-1:0] : '0;
  assign busy         = run || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign pass         = done && (err_count == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; start only honoured when idle or finished.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        if (dcnt == 4'(LAT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain timer: LAT cycles for the last results to return.
  always_ff @(posedge clk) begin
    if (rst || state_q != DRAIN) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // Check pipe mirrors the datapath latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= dp.dut_valid;
      pa[0] <= dp.dut_a;
      pb[0] <= dp.dut_b;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign mis = pv[LAT-1] &&
    (dp.dut_y != WIDTH'(nand_gold(
      16'(pa[LAT-1]), 16'(pb[LAT-1]))));

  // Error count (saturating) and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (mis) begin
      if (err_count != '1) err_count <= err_count + 1'b1;
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_a     <= pa[LAT-1];
        fail_b     <= pb[LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_nand_bist_ctrl.sv
// Directed bench for nand_bist_ctrl (counter pattern source).
// Two instances: ERRW=8 with a selectable fault model, ERRW=4 stuck-at-0.
module tb_nand_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   mode = 0;

  always #5 clk = ~clk;

  nand_bist_if #(.WIDTH(4)) dp0 ();
  nand_bist_if #(.WIDTH(4)) dp1 ();

  logic       busy0, done0, pass0, fv0;
  logic [7:0] err0;
  logic [3:0] fa0, fb0;
  logic       busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [3:0] fa1, fb1;

  nand_bist_ctrl #(.WIDTH(4), .LAT(2), .ERRW(8)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start0),
    .dp         (dp0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .err_count  (err0),
    .fail_valid (fv0),
    .fail_a     (fa0),
    .fail_b     (fb0)
  );

  nand_bist_ctrl #(.WIDTH(4), .LAT(2), .ERRW(4)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .dp         (dp1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_count  (err1),
    .fail_valid (fv1),
    .fail_a     (fa1),
    .fail_b     (fb1)
  );

  // Two-stage NAND model; mode 1 forces y[0] high.
  logic [3:0] p1, y0;
  always_ff @(posedge clk) begin
    if (mode == 1) p1 <= ~(dp0.dut_a & dp0.dut_b) | 4'b0001;
    else           p1 <= ~(dp0.dut_a & dp0.dut_b);
    y0 <= p1;
  end
  assign dp0.dut_y = y0;
  assign dp1.dut_y = 4'h0;

  task automatic run0(output int n);
    n = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (busy0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy0, done0, pass0, err0, fv0, fa0, fb0} !== '0) begin
      bad++;
      $display("FAIL reset_status0 got %h want 0",
        {busy0, done0, pass0, err0, fv0, fa0, fb0});
    end
    total++;
    if ({dp0.dut_valid, dp0.dut_a, dp0.dut_b} !== '0) begin
      bad++;
      $display("FAIL reset_bus0 got %h want 0",
        {dp0.dut_valid, dp0.dut_a, dp0.dut_b});
    end
    total++;
    if ({busy1, done1, err1, fv1, dp1.dut_valid} !== '0) begin
      bad++;
      $display("FAIL reset_status1 got %h want 0",
        {busy1, done1, err1, fv1, dp1.dut_valid});
    end
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({busy0, dp0.dut_valid, done0} !== 3'b000) begin
        bad++;
        $display("FAIL idle_quiet got %b want 000",
          {busy0, dp0.dut_valid, done0});
      end
    end
  endtask

  task automatic test_ideal();
    int n;
    mode = 0;
    run0(n);
    total++;
    if (n != 258) begin
      bad++;
      $display("FAIL ideal_busy got %0d want 258", n);
    end
    total++;
    if ({done0, pass0, err0, fv0} !== {1'b1, 1'b1, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL ideal_status got d=%b p=%b e=%0d fv=%b want 1 1 0 0",
        done0, pass0, err0, fv0);
    end
  endtask

  task automatic test_stuck1();
    int n;
    mode = 1;
    run0(n);
    total++;
    if (n != 258) begin
      bad++;
      $display("FAIL stuck1_busy got %0d want 258", n);
    end
    total++;
    if (err0 !== 8'd64) begin
      bad++;
      $display("FAIL stuck1_err got %0d want 64", err0);
    end
    total++;
    if ({fv0, fa0, fb0} !== {1'b1, 4'h1, 4'h1}) begin
      bad++;
      $display("FAIL stuck1_first got fv=%b a=%h b=%h want 1 1 1",
        fv0, fa0, fb0);
    end
    total++;
    if ({done0, pass0} !== 2'b10) begin
      bad++;
      $display("FAIL stuck1_pass got %b want 10", {done0, pass0});
    end
  endtask

  task automatic test_saturate();
    int n = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (busy1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 258) begin
      bad++;
      $display("FAIL sat_busy got %0d want 258", n);
    end
    total++;
    if (err1 !== 4'd15) begin
      bad++;
      $display("FAIL sat_err got %0d want 15", err1);
    end
    total++;
    if ({fv1, fa1, fb1, done1, pass1} !== {1'b1, 8'h00, 2'b10}) begin
      bad++;
      $display("FAIL sat_first got fv=%b a=%h b=%h d=%b p=%b want 1 0 0 1 0",
        fv1, fa1, fb1, done1, pass1);
    end
  endtask

  task automatic test_ignore_start();
    int n = 0;
    mode = 0;
    start0 = 1'b1;
    @(negedge clk);
    total++;
    if ({done0, err0, fv0, busy0} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL restart_clear got d=%b e=%0d fv=%b b=%b want 0 0 0 1",
        done0, err0, fv0, busy0);
    end
    while (busy0 && n < 2000) begin
      n++;
      start0 = (n == 10 || n == 200);
      @(negedge clk);
    end
    start0 = 1'b0;
    total++;
    if (n != 258) begin
      bad++;
      $display("FAIL ignore_busy got %0d want 258", n);
    end
    total++;
    if ({done0, pass0, err0} !== {2'b11, 8'd0}) begin
      bad++;
      $display("FAIL ignore_status got d=%b p=%b e=%0d want 1 1 0",
        done0, pass0, err0);
    end
    run0(n);
    total++;
    if (n != 258 || pass0 !== 1'b1) begin
      bad++;
      $display("FAIL rerun got busy=%0d p=%b want 258 1", n, pass0);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    mode = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (busy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy0, done0, pass0, err0, fv0, fa0, fb0,
         dp0.dut_valid, dp0.dut_a, dp0.dut_b} !== '0) begin
      bad++;
      $display("FAIL midrst_zero got b=%b d=%b e=%0d fv=%b v=%b want all 0",
        busy0, done0, err0, fv0, dp0.dut_valid);
    end
    mode = 0;
    repeat (3) @(negedge clk);
    run0(n);
    total++;
    if (n != 258) begin
      bad++;
      $display("FAIL midrst_busy got %0d want 258", n);
    end
    total++;
    if ({done0, pass0, err0, fv0} !== {2'b11, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_status got d=%b p=%b e=%0d fv=%b want 1 1 0 0",
        done0, pass0, err0, fv0);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck1();
    test_saturate();
    test_ignore_start();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
